// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave register-access frame sequencer.
package spi_pkg;

    localparam int unsigned DATA_W       = 8;
    localparam int unsigned ADDR_W       = 7;
    localparam int unsigned CMD_RW_BIT   = 7;
    localparam int unsigned CMD_ADDR_MSB = 6;

    localparam logic [DATA_W-1:0] ERR_FILL  = 8'hFF;
    localparam logic [DATA_W-1:0] IDLE_FILL = 8'h00;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WR,
        RD_REQ,
        RD_CAP,
        RD,
        ERR
    } state_e;

    // Next burst address, wrapping the last valid register back to 0.
    function automatic logic [ADDR_W-1:0] addr_inc(logic [ADDR_W-1:0] addr, int unsigned nregs);
        if (addr == ADDR_W'(nregs - 1)) begin
            return '0;
        end
        return addr + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/spi_slave_reg_ctrl_if.sv
// Byte-engine / register-bank signal bundle seen by the frame sequencer.
interface spi_slave_reg_ctrl_if;
    import spi_pkg::*;

    logic              cs;
    logic [DATA_W-1:0] rx_data;
    logic              rx_done;
    logic [DATA_W-1:0] tx_data;
    logic [ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0] reg_wdata;
    logic              reg_we;
    logic              reg_re;
    logic [DATA_W-1:0] reg_rdata;
    logic              frame_err;
    logic              busy;

    modport slave (
        input  cs, rx_data, rx_done, reg_rdata,
        output tx_data, reg_addr, reg_wdata, reg_we, reg_re, frame_err, busy
    );

    modport master (
        output cs, rx_data, rx_done, reg_rdata,
        input  tx_data, reg_addr, reg_wdata, reg_we, reg_re, frame_err, busy
    );

endinterface

// File: rtl/spi_slave_reg_ctrl_byte_strobe.sv
// Rising-edge detector on the byte engine's rx_done level; one pulse per received byte.
module spi_byte_strobe (
    input  logic spi_clk,
    input  logic reset,
    input  logic rx_done_i,
    output logic byte_stb_c_o
);

    logic rx_done_q;

    // History resets high so a level already up at reset release is not a new byte.
    always_ff @(posedge spi_clk) begin
        if (!reset) begin
            rx_done_q <= 1'b1;
        end else begin
            rx_done_q <= rx_done_i;
        end
    end

    assign byte_stb_c_o = rx_done_i & ~rx_done_q;

endmodule

// File: rtl/spi_slave_reg_ctrl.sv
// SPI frame sequencer: command byte + data bytes -> register write/read strobes and tx data.
// Define SPI_REG_AUTOINC_EN to auto-increment the register address across a burst.
module spi_slave_reg_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned NREGS = 16
) (
    input  logic                 spi_clk,
    input  logic                 reset,
    spi_slave_reg_ctrl_if.slave  bus
);

    state_e            state_q;
    logic [DATA_W-1:0] tx_data_q;
    logic [ADDR_W-1:0] reg_addr_q;
    logic [DATA_W-1:0] reg_wdata_q;
    logic              reg_we_q;
    logic              reg_re_q;
    logic              frame_err_q;
    logic              busy_q;
    logic              byte_stb;

    spi_byte_strobe u_byte_strobe (
        .spi_clk      (spi_clk),
        .reset        (reset),
        .rx_done_i    (bus.rx_done),
        .byte_stb_c_o (byte_stb)
    );

    // reg_re is raised on entry to RD_REQ so the bank's read data lands during RD_CAP.
    always_ff @(posedge spi_clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            tx_data_q   <= IDLE_FILL;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            reg_we_q <= 1'b0;
            reg_re_q <= 1'b0;
            if (bus.cs) begin
                state_q     <= IDLE;
                tx_data_q   <= IDLE_FILL;
                frame_err_q <= 1'b0;
                busy_q      <= 1'b0;
            end else begin
                // With cs low every state, including IDLE, lands somewhere other than IDLE.
                busy_q <= 1'b1;
                case (state_q)
                    IDLE: state_q <= CMD;
                    CMD: begin
                        if (byte_stb) begin
                            reg_addr_q <= bus.rx_data[CMD_ADDR_MSB:0];
                            if ({1'b0, bus.rx_data[CMD_ADDR_MSB:0]} >= 8'(NREGS)) begin
                                state_q     <= ERR;
                                frame_err_q <= 1'b1;
                                tx_data_q   <= ERR_FILL;
                            end else if (bus.rx_data[CMD_RW_BIT]) begin
                                state_q  <= RD_REQ;
                                reg_re_q <= 1'b1;
                            end else begin
                                state_q <= WR;
                            end
                        end
                    end
                    WR: begin
                        if (byte_stb) begin
                            reg_wdata_q <= bus.rx_data;
                            reg_we_q    <= 1'b1;
                        end
`ifdef SPI_REG_AUTOINC_EN
                        // Advance only after the strobe cycle so the write sees the current address.
                        if (reg_we_q) begin
                            reg_addr_q <= addr_inc(reg_addr_q, NREGS);
                        end
`endif
                    end
                    RD_REQ: begin
                        if (byte_stb) begin
                            frame_err_q <= 1'b1;
                        end
                        state_q <= RD_CAP;
                    end
                    RD_CAP: begin
                        if (byte_stb) begin
                            frame_err_q <= 1'b1;
                        end
                        tx_data_q <= bus.reg_rdata;
                        state_q   <= RD;
                    end
                    RD: begin
                        if (byte_stb) begin
`ifdef SPI_REG_AUTOINC_EN
                            reg_addr_q <= addr_inc(reg_addr_q, NREGS);
`endif
                            reg_re_q <= 1'b1;
                            state_q  <= RD_REQ;
                        end
                    end
                    ERR:     tx_data_q <= ERR_FILL;
                    default: state_q   <= IDLE;
                endcase
            end
        end
    end

    assign bus.tx_data   = tx_data_q;
    assign bus.reg_addr  = reg_addr_q;
    assign bus.reg_wdata = reg_wdata_q;
    assign bus.reg_we    = reg_we_q;
    assign bus.reg_re    = reg_re_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_spi_slave_reg_ctrl.sv
// Bench for spi_slave_reg_ctrl: directed frames, transaction scoreboard and per-cycle rule checks.
module tb_spi_slave_reg_ctrl;

    localparam int NREGS = 16;
    localparam int GAP   = 6;
`ifdef SPI_REG_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    typedef struct packed {
        logic [6:0] a;
        logic [7:0] d;
    } wr_t;

    logic spi_clk = 1'b0;
    logic reset   = 1'b0;

    spi_slave_reg_ctrl_if bus ();

    spi_slave_reg_ctrl #(.NREGS(NREGS)) dut (
        .spi_clk (spi_clk),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 spi_clk = ~spi_clk;

    int errors = 0;
    int checks = 0;

    wr_t        exp_wr[$];
    logic [6:0] exp_rd[$];
    wr_t        w;
    logic [6:0] ra;
    bit         expect_err = 1'b0;
    bit         seen_edge  = 1'b0;
    logic       cs_e;
    logic       rst_e;
    logic [7:0] mem [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] exp_addr(input int base, input int k);
        return 7'(AUTOINC ? (base + k) % NREGS : base);
    endfunction

    // Register bank fixture: read data is registered, valid the cycle after reg_re.
    always @(posedge spi_clk) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'(i * 17);
            mem[5]        <= 8'h3C;
            mem[6]        <= 8'h7E;
            bus.reg_rdata <= 8'h00;
        end else begin
            if (bus.reg_we) mem[bus.reg_addr[3:0]] <= bus.reg_wdata;
            if (bus.reg_re) bus.reg_rdata <= mem[bus.reg_addr[3:0]];
        end
        cs_e      <= bus.cs;
        rst_e     <= reset;
        seen_edge <= 1'b1;
    end

    // Per-cycle rule checks plus write/read transaction scoreboard.
    always @(negedge spi_clk) begin
        if (seen_edge) begin
            if (!rst_e) begin
                chk("rst_tx_data",   bus.tx_data,   8'h00);
                chk("rst_reg_addr",  bus.reg_addr,  0);
                chk("rst_reg_wdata", bus.reg_wdata, 0);
                chk("rst_reg_we",    bus.reg_we,    0);
                chk("rst_reg_re",    bus.reg_re,    0);
                chk("rst_frame_err", bus.frame_err, 0);
                chk("rst_busy",      bus.busy,      0);
            end else begin
                chk("busy", bus.busy, 32'(!cs_e));
                chk("we_re_exclusive", 32'(bus.reg_we & bus.reg_re), 0);
                if (cs_e) begin
                    chk("cs_hi_tx_data",   bus.tx_data,   8'h00);
                    chk("cs_hi_frame_err", bus.frame_err, 0);
                    chk("cs_hi_reg_we",    bus.reg_we,    0);
                    chk("cs_hi_reg_re",    bus.reg_re,    0);
                end else begin
                    chk("frame_err", bus.frame_err, 32'(expect_err));
                    if (expect_err) chk("err_tx_fill", bus.tx_data, 8'hFF);
                end
                if (bus.reg_we) begin
                    if (exp_wr.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: got addr %0h data %0h want no write (t=%0t)",
                                 bus.reg_addr, bus.reg_wdata, $time);
                    end else begin
                        w = exp_wr.pop_front();
                        chk("wr_addr", bus.reg_addr, w.a);
                        chk("wr_data", bus.reg_wdata, w.d);
                    end
                end
                if (bus.reg_re) begin
                    if (exp_rd.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_read: got addr %0h want no read (t=%0t)",
                                 bus.reg_addr, $time);
                    end else begin
                        ra = exp_rd.pop_front();
                        chk("rd_addr", bus.reg_addr, ra);
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge spi_clk);
            #1;
        end
    endtask

    task automatic pulse(input logic [7:0] b);
        bus.rx_data = b;
        bus.rx_done = 1'b1;
        step(1);
        bus.rx_done = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        pulse(b);
        step(GAP);
    endtask

    task automatic start_frame();
        bus.cs = 1'b0;
        step(2);
    endtask

    task automatic end_frame();
        bus.cs = 1'b1;
        step(1);
        expect_err = 1'b0;
        step(3);
    endtask

    initial begin
        bus.cs      = 1'b1;
        bus.rx_data = 8'h00;
        bus.rx_done = 1'b0;
        reset       = 1'b0;
        step(3);
        reset = 1'b1;
        step(2);

        // Single write.
        start_frame();
        exp_wr.push_back('{a: 7'd3, d: 8'hA5});
        send(8'h03);
        send(8'hA5);
        end_frame();

        // Write burst starting at the last register.
        start_frame();
        exp_wr.push_back('{a: 7'd15, d: 8'h11});
        exp_wr.push_back('{a: exp_addr(15, 1), d: 8'h22});
        send(8'h0F);
        send(8'h11);
        send(8'h22);
        end_frame();

        // Read with two dummy bytes; tx_data checked two edges after each strobe.
        start_frame();
        exp_rd.push_back(7'd5);
        exp_rd.push_back(exp_addr(5, 1));
        exp_rd.push_back(exp_addr(5, 2));
        pulse(8'h85);
        step(2);
        chk("rd_tx_first", bus.tx_data, 8'h3C);
        step(GAP);
        pulse(8'h00);
        step(2);
        chk("rd_tx_second", bus.tx_data, AUTOINC ? 8'h7E : 8'h3C);
        step(GAP);
        pulse(8'h00);
        step(2);
        chk("rd_tx_third", bus.tx_data, AUTOINC ? 8'h77 : 8'h3C);
        step(GAP);
        end_frame();

        // Out-of-range address poisons the frame until cs rises.
        start_frame();
        pulse(8'h20);
        expect_err = 1'b1;
        step(GAP);
        send(8'h55);
        chk("bad_addr_err", bus.frame_err, 1);
        end_frame();
        chk("bad_addr_err_cleared", bus.frame_err, 0);
        chk("bad_addr_tx_cleared", bus.tx_data, 8'h00);

        // Reset in the middle of a write frame; next byte is a fresh command.
        start_frame();
        send(8'h02);
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        step(2);
        chk("post_rst_busy", bus.busy, 1);
        exp_wr.push_back('{a: 7'd4, d: 8'h77});
        send(8'h04);
        send(8'h77);
        end_frame();

        // cs raised while waiting for read data.
        start_frame();
        exp_rd.push_back(7'd5);
        pulse(8'h85);
        step(1);
        bus.cs = 1'b1;
        step(1);
        chk("abort_busy", bus.busy, 0);
        chk("abort_tx", bus.tx_data, 8'h00);
        step(3);
        start_frame();
        exp_wr.push_back('{a: 7'd7, d: 8'h5A});
        send(8'h07);
        send(8'h5A);
        end_frame();

        step(4);
        chk("wr_queue_drained", exp_wr.size(), 0);
        chk("rd_queue_drained", exp_rd.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
